// File: rtl/wb_load_align.sv
// Writeback stage: captures completing instructions, waits on late load data,
// aligns/extends loads and drives the register-file write port.
// Optional `MISALIGN_CHECK_EN adds the MISALIGN_EXC pulse output.
module wb_load_align (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        VALID_IN,
  input  logic [4:0]  RD_IN,
  input  logic        RD_WB_EN_IN,
  input  logic        IS_LOAD_IN,
  input  logic [2:0]  FUNCT3_IN,
  input  logic [1:0]  ADDR_LSB_IN,
  input  logic [31:0] ALU_RESULT_IN,
  input  logic [31:0] DCACHE_RDATA,
  input  logic        DCACHE_RVALID,
  input  logic        FLUSH,
  output logic        STALL_OUT,
  output logic [31:0] DATA_OUT,
  output logic        RD_WB_VALID_OUT,
  output logic [4:0]  RD_WB_OUT
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        MISALIGN_EXC
`endif
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [RW-1:0]   rd_out_q, rd_out_d;
  logic            strobe_q, strobe_d;
  logic [RW-1:0]   pend_rd_q, pend_rd_d;
  logic            pend_en_q, pend_en_d;
  logic [2:0]      pend_f3_q, pend_f3_d;
  logic [1:0]      pend_lsb_q, pend_lsb_d;
  logic            misalign_c;
  logic            accept_c;

  // Byte/halfword lane select and sign/zero extension of an aligned cache word.
  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] w,
                                                 input logic [2:0]      f3,
                                                 input logic [1:0]      lsb);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lsb, 3'b000} +: 8];
    h = lsb[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  align_load = {{24{b[7]}}, b};
      3'b100:  align_load = {24'h000000, b};
      3'b001:  align_load = {{16{h[15]}}, h};
      3'b101:  align_load = {16'h0000, h};
      default: align_load = w;
    endcase
  endfunction

`ifdef MISALIGN_CHECK_EN
  logic exc_q, exc_d;
  // LH/LHU (f3[1:0]==01) need an even address; LW needs a word address.
  assign misalign_c = IS_LOAD_IN &
                      (((FUNCT3_IN[1:0] == 2'b01) & ADDR_LSB_IN[0]) |
                       ((FUNCT3_IN == 3'b010) & (ADDR_LSB_IN != 2'b00)));
  assign MISALIGN_EXC = exc_q;
`else
  assign misalign_c = 1'b0;
`endif

  assign accept_c = (state_q == S_IDLE) & VALID_IN & ~FLUSH;

  // Reset also masks the stall so upstream never freezes on reset.
  assign STALL_OUT = RST_N & ~DCACHE_RVALID & ~FLUSH &
                     (((state_q == S_IDLE) & VALID_IN & IS_LOAD_IN & ~misalign_c) |
                      (state_q == S_WAIT));

  assign DATA_OUT        = data_q;
  assign RD_WB_OUT       = rd_out_q;
  assign RD_WB_VALID_OUT = strobe_q;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    rd_out_d   = rd_out_q;
    strobe_d   = 1'b0;
    pend_rd_d  = pend_rd_q;
    pend_en_d  = pend_en_q;
    pend_f3_d  = pend_f3_q;
    pend_lsb_d = pend_lsb_q;
`ifdef MISALIGN_CHECK_EN
    exc_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (!IS_LOAD_IN) begin
            data_d   = ALU_RESULT_IN;
            rd_out_d = RD_IN;
            strobe_d = RD_WB_EN_IN & (RD_IN != '0);
          end else if (misalign_c) begin
`ifdef MISALIGN_CHECK_EN
            exc_d = 1'b1;
`endif
          end else if (DCACHE_RVALID) begin
            data_d   = align_load(DCACHE_RDATA, FUNCT3_IN, ADDR_LSB_IN);
            rd_out_d = RD_IN;
            strobe_d = RD_WB_EN_IN & (RD_IN != '0);
          end else begin
            pend_rd_d  = RD_IN;
            pend_en_d  = RD_WB_EN_IN;
            pend_f3_d  = FUNCT3_IN;
            pend_lsb_d = ADDR_LSB_IN;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Flush wins over data arriving in the same cycle.
        if (FLUSH) begin
          state_d = S_IDLE;
        end else if (DCACHE_RVALID) begin
          data_d   = align_load(DCACHE_RDATA, pend_f3_q, pend_lsb_q);
          rd_out_d = pend_rd_q;
          strobe_d = pend_en_q & (pend_rd_q != '0);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      data_q     <= '0;
      rd_out_q   <= '0;
      strobe_q   <= 1'b0;
      pend_rd_q  <= '0;
      pend_en_q  <= 1'b0;
      pend_f3_q  <= '0;
      pend_lsb_q <= '0;
`ifdef MISALIGN_CHECK_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      rd_out_q   <= rd_out_d;
      strobe_q   <= strobe_d;
      pend_rd_q  <= pend_rd_d;
      pend_en_q  <= pend_en_d;
      pend_f3_q  <= pend_f3_d;
      pend_lsb_q <= pend_lsb_d;
`ifdef MISALIGN_CHECK_EN
      exc_q      <= exc_d;
`endif
    end
  end

endmodule

// File: doc/wb_load_align.md
# wb_load_align

Final pipeline stage between the MEM3 data-cache response and the integer register array. It captures completing instructions, waits for outstanding load data, extracts and sign/zero-extends byte/halfword/word loads, and presents a registered writeback (data, destination, valid) to the register file. It stalls the upstream pipeline while a load waits for data.

## Interface
Parameters:
- none

Ports:
- `CLK`  in  1  system clock, all state updates on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `VALID_IN`  in  1  MEM3 stage holds a valid instruction
- `RD_IN`  in  5  destination register
- `RD_WB_EN_IN`  in  1  instruction writes `RD_IN`
- `IS_LOAD_IN`  in  1  instruction is a load
- `FUNCT3_IN`  in  3  load width/sign code
- `ADDR_LSB_IN`  in  2  load address bits [1:0]
- `ALU_RESULT_IN`  in  32  non-load result
- `DCACHE_RDATA`  in  32  cache read word, aligned to a word boundary
- `DCACHE_RVALID`  in  1  `DCACHE_RDATA` valid this cycle
- `FLUSH`  in  1  kill the instruction in this stage
- `STALL_OUT`  out  1  upstream must hold its inputs
- `DATA_OUT`  out  32  writeback data to the register array
- `RD_WB_VALID_OUT`  out  1  writeback strobe
- `RD_WB_OUT`  out  5  writeback register index
- `MISALIGN_EXC`  out  1  misaligned-load pulse; present only with `MISALIGN_CHECK_EN`

## Operation
- FSM with two states: `IDLE` and `WAIT`.
- **IDLE, accepting an instruction.** An instruction is accepted when `VALID_IN` is high and `FLUSH` is low.
  - Non-load, or a load with `DCACHE_RVALID` high in the same cycle: the result is captured into the output registers at the next edge. State stays `IDLE`.
  - Load with `DCACHE_RVALID` low: `RD_IN`, `RD_WB_EN_IN`, `FUNCT3_IN` and `ADDR_LSB_IN` are latched, and the FSM moves to `WAIT`.
- **WAIT.**
  - On `DCACHE_RVALID`: the aligned data is captured and the FSM returns to `IDLE`.
  - New `VALID_IN` inputs are not accepted while in `WAIT`.
- **Stall.** `STALL_OUT` = (`IDLE` & `VALID_IN` & `IS_LOAD_IN` & !`DCACHE_RVALID` & !`FLUSH`) | (`WAIT` & !`DCACHE_RVALID` & !`FLUSH`). It is combinational.
- **Load alignment** (by `FUNCT3_IN`):
  - 000 LB: byte at bits [8·lsb+7 : 8·lsb], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: halfword at bits [16·lsb[1]+15 : 16·lsb[1]], sign-extended.
  - 101 LHU: same halfword, zero-extended.
  - 010 LW, and the reserved codes 011/110/111: full word, no shift.
- **Writeback strobe.** `RD_WB_VALID_OUT` = captured & `RD_WB_EN` & (rd ≠ 0). An rd of 0 never strobes, but `DATA_OUT` still updates.
- **Flush.**
  - `FLUSH` in `IDLE`: the input is dropped and there is no strobe.
  - `FLUSH` in `WAIT`: returns to `IDLE` with no strobe. `FLUSH` has priority over a simultaneous `DCACHE_RVALID`.
- **Stray cache data.** `DCACHE_RVALID` in `IDLE` with no accepted load is ignored. This includes a late response to a flushed load.

## Timing
- **Reset** (`RST_N` low, asynchronous): `DATA_OUT`=0, `RD_WB_VALID_OUT`=0, `RD_WB_OUT`=0, `MISALIGN_EXC`=0, state=`IDLE`. `STALL_OUT` is forced to 0 while `RST_N` is low. Reset mid-`WAIT` discards the pending load.
- **Latency** is measured from the accepting edge (or the `DCACHE_RVALID` edge) to the registered outputs:
  - Non-load: 1 cycle.
  - Load with data in the accept cycle: 1 cycle.
  - Load with late data: 1 cycle after the `DCACHE_RVALID` cycle.
- **Output hold.** `RD_WB_VALID_OUT` is high for exactly one cycle per completed instruction. `DATA_OUT` and `RD_WB_OUT` hold their last values until the next capture.
- **Throughput:** back-to-back non-loads or hit loads complete one per cycle.
- **Upstream contract:** inputs must remain stable while `STALL_OUT` is high.

## Configuration
- **Macro:** `MISALIGN_CHECK_EN`.
- **Defined:**
  - A misaligned load is LH/LHU with lsb[0]=1, or LW with lsb≠0.
  - It is accepted with no wait, produces no writeback strobe, and does not assert `STALL_OUT`.
  - `MISALIGN_EXC` pulses high for one cycle, on the same cycle a strobe would have appeared.
- **Undefined:**
  - The `MISALIGN_EXC` port is absent.
  - Misaligned loads use the alignment rules above: lsb[0] is ignored for halfwords, and lsb is ignored for words.

## Test plan
- ALU result 0xDEADBEEF, rd=5, non-load, in `IDLE` → next cycle `DATA_OUT`=0xDEADBEEF, `RD_WB_OUT`=5, `RD_WB_VALID_OUT`=1 for one cycle.
- LB with lsb=3, `DCACHE_RDATA`=0x80FF_0000, data 3 cycles late → `STALL_OUT` high 3 cycles, then `DATA_OUT`=0xFFFFFF80, strobe rd.
- LHU with lsb=2, `DCACHE_RDATA`=0x9ABC_1234 hit → `DATA_OUT`=0x00009ABC; LH with the same data → 0xFFFF9ABC.
- Load rd=0 hit → `DATA_OUT` updates, `RD_WB_VALID_OUT` stays 0. Load in `WAIT` with `FLUSH` and `DCACHE_RVALID` in the same cycle → no strobe, returns to `IDLE`.
- `RST_N` low during `WAIT` → all outputs 0 immediately, `STALL_OUT`=0, and a later `DCACHE_RVALID` is ignored.
- With `MISALIGN_CHECK_EN`: LW with lsb=1 → `MISALIGN_EXC` one-cycle pulse, no strobe, no stall.
